// File: rtl/fs_pkg.sv
// Shared constants and types for the /dev/mem filesystem server:
// path words, open-file encoding and the path decoder's state set.
package fs_pkg;

    localparam logic [31:0] PATH_DEV  = "/dev";
    localparam logic [31:0] PATH_MEM  = "/mem";
    localparam logic [31:0] PATH_META = "meta";

    localparam logic [1:0] FILE_NONE = 2'd0;
    localparam logic [1:0] FILE_MEM  = 2'd1;
    localparam logic [1:0] FILE_META = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEV       = 3'd1,
        ST_MEM       = 3'd2,
        ST_META      = 3'd3,
        ST_OPEN_MEM  = 3'd4,
        ST_OPEN_META = 3'd5
    } path_state_e;

    function automatic logic [1:0] open_of(input path_state_e s);
        case (s)
            ST_OPEN_MEM:  return FILE_MEM;
            ST_OPEN_META: return FILE_META;
            default:      return FILE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fs_path_decoder.sv
// Walks the streamed path words into an open-file state. Only a change of
// fs_filename advances the walk; any unexpected word drops back to idle.
module fs_path_decoder
    import fs_pkg::*;
#(
    parameter logic [31:0] PATH_1 = PATH_DEV,
    parameter logic [31:0] PATH_2 = PATH_MEM,
    parameter logic [31:0] PATH_3 = PATH_META
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fs_filename,
    output logic [1:0]  open_file,
    output logic [1:0]  open_file_next,
    output logic        bad_path
);

    path_state_e state_q, state_d;
    logic [31:0] prev_name_q, prev_name_d;
    logic        bad_path_q, bad_path_d;
    logic        name_zero;
    logic        state_closed;

    assign name_zero    = (fs_filename == 32'd0);
    assign state_closed = (state_q == ST_IDLE) || (state_q == ST_OPEN_MEM) ||
                          (state_q == ST_OPEN_META);

    always_comb begin
        state_d     = state_q;
        prev_name_d = prev_name_q;
        bad_path_d  = bad_path_q;
        if (fs_filename != prev_name_q) begin
            prev_name_d = fs_filename;
            // PATH_1 restarts the walk from anywhere, closing whatever was open.
            if (fs_filename == PATH_1) begin
                state_d = ST_DEV;
            end else if (state_q == ST_DEV && fs_filename == PATH_2) begin
                state_d = ST_MEM;
            end else if (state_q == ST_MEM && name_zero) begin
                state_d = ST_OPEN_MEM;
            end else if (state_q == ST_MEM && fs_filename == PATH_3) begin
                state_d = ST_META;
            end else if (state_q == ST_META && name_zero) begin
                state_d = ST_OPEN_META;
            end else if (state_closed && name_zero) begin
                state_d = ST_IDLE;
            end else begin
                state_d    = ST_IDLE;
                bad_path_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prev_name_q <= 32'd0;
            bad_path_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_name_q <= prev_name_d;
            bad_path_q  <= bad_path_d;
        end
    end

    assign open_file      = open_of(state_q);
    assign open_file_next = open_of(state_d);
    assign bad_path       = bad_path_q;

endmodule

// File: rtl/fs_dev_mem.sv
// Filesystem-side server for paged-RAM swap traffic: maps /dev/mem and
// /dev/memmeta word accesses onto a synchronous backing store, 2-cycle reads.
module fs_dev_mem
    import fs_pkg::*;
#(
    parameter int unsigned BS_AW      = 16,
    parameter int unsigned MEM_AW     = 15,
    parameter int unsigned META_BASE  = 32768,
    parameter int unsigned META_DEPTH = 1024,
    parameter logic [31:0] PATH_1     = PATH_DEV,
    parameter logic [31:0] PATH_2     = PATH_MEM,
    parameter logic [31:0] PATH_3     = PATH_META
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fs_access,
    input  logic             fs_rden,
    input  logic             fs_wren,
    input  logic [31:0]      fs_filename,
    input  logic [31:0]      fs_address,
    input  logic [31:0]      fs_data,
    output logic [31:0]      fs_q,
    output logic             bs_wr_en,
    output logic [BS_AW-1:0] bs_wr_addr,
    output logic [31:0]      bs_wr_data,
    output logic             bs_rd_en,
    output logic [BS_AW-1:0] bs_rd_addr,
    input  logic [31:0]      bs_rd_data,
    output logic [1:0]       open_file,
    output logic             bad_path,
    output logic             bad_access
);

    logic [1:0]       file_next;
    logic             acc_legal;
    logic [BS_AW-1:0] acc_addr;
    logic             unused_fs_access;

    // Stage 1: registered request, drives the backing store directly.
    logic             wr_en_q, wr_en_d;
    logic [BS_AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic             rd_req_q, rd_req_d;
    logic             rd_en_q, rd_en_d;
    logic [BS_AW-1:0] rd_addr_q, rd_addr_d;
    logic             fwd_q, fwd_d;
    logic [31:0]      fwd_data_q, fwd_data_d;
    // Stage 2: aligned with the store's read data.
    logic             rd_req2_q, rd_req2_d;
    logic             rd_ok2_q, rd_ok2_d;
    logic             fwd2_q, fwd2_d;
    logic [31:0]      fwd_data2_q, fwd_data2_d;
    logic [31:0]      fs_q_q, fs_q_d;
    logic             bad_access_q, bad_access_d;

    assign unused_fs_access = fs_access;

    fs_path_decoder #(
        .PATH_1 (PATH_1),
        .PATH_2 (PATH_2),
        .PATH_3 (PATH_3)
    ) u_path (
        .clk            (clk),
        .rst_n          (rst_n),
        .fs_filename    (fs_filename),
        .open_file      (open_file),
        .open_file_next (file_next),
        .bad_path       (bad_path)
    );

    // Decode against the file opened by this same edge's path step.
    always_comb begin
        acc_legal = 1'b0;
        acc_addr  = '0;
        case (file_next)
            FILE_MEM: begin
                acc_legal = ((fs_address >> MEM_AW) == 32'd0);
                acc_addr  = fs_address[BS_AW-1:0];
            end
            FILE_META: begin
                acc_legal = (fs_address < META_DEPTH);
                acc_addr  = BS_AW'(META_BASE) + fs_address[BS_AW-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_en_d    = fs_wren & acc_legal;
        wr_addr_d  = acc_addr;
        wr_data_d  = fs_data;
        rd_req_d   = fs_rden;
        rd_en_d    = fs_rden & acc_legal;
        rd_addr_d  = acc_addr;
        fwd_d      = 1'b0;
        fwd_data_d = fs_data;
        // A same-edge write is newer than the one already in stage 1.
        if (fs_rden && acc_legal && fs_wren) begin
            fwd_d = 1'b1;
        end else if (fs_rden && acc_legal && wr_en_q && (wr_addr_q == acc_addr)) begin
            fwd_d      = 1'b1;
            fwd_data_d = wr_data_q;
        end
        bad_access_d = bad_access_q | ((fs_rden | fs_wren) & ~acc_legal);

        rd_req2_d   = rd_req_q;
        rd_ok2_d    = rd_en_q;
        fwd2_d      = fwd_q;
        fwd_data2_d = fwd_data_q;

        fs_q_d = fs_q_q;
        if (rd_req2_q) begin
            fs_q_d = fwd2_q ? fwd_data2_q : (rd_ok2_q ? bs_rd_data : 32'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 32'd0;
            rd_req_q     <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            fwd_q        <= 1'b0;
            fwd_data_q   <= 32'd0;
            rd_req2_q    <= 1'b0;
            rd_ok2_q     <= 1'b0;
            fwd2_q       <= 1'b0;
            fwd_data2_q  <= 32'd0;
            fs_q_q       <= 32'd0;
            bad_access_q <= 1'b0;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_req_q     <= rd_req_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            fwd_q        <= fwd_d;
            fwd_data_q   <= fwd_data_d;
            rd_req2_q    <= rd_req2_d;
            rd_ok2_q     <= rd_ok2_d;
            fwd2_q       <= fwd2_d;
            fwd_data2_q  <= fwd_data2_d;
            fs_q_q       <= fs_q_d;
            bad_access_q <= bad_access_d;
        end
    end

    assign bs_wr_en   = wr_en_q;
    assign bs_wr_addr = wr_addr_q;
    assign bs_wr_data = wr_data_q;
    assign bs_rd_en   = rd_en_q;
    assign bs_rd_addr = rd_addr_q;
    assign fs_q       = fs_q_q;
    assign bad_access = bad_access_q;

endmodule

// File: tb/tb_fs_dev_mem.sv
// Scoreboard bench for fs_dev_mem: a path/file reference model predicts each
// edge's strobes, status and read data; a monitor compares as outputs appear.
module tb_fs_dev_mem;

    localparam logic [31:0] P1  = "/dev";
    localparam logic [31:0] P2  = "/mem";
    localparam logic [31:0] P3  = "meta";
    localparam logic [31:0] BAD = "/foo";

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fs_access = 1'b0;
    logic        fs_rden = 1'b0;
    logic        fs_wren = 1'b0;
    logic [31:0] fs_filename = 32'd0;
    logic [31:0] fs_address = 32'd0;
    logic [31:0] fs_data = 32'd0;
    logic [31:0] fs_q;
    logic        bs_wr_en;
    logic [15:0] bs_wr_addr;
    logic [31:0] bs_wr_data;
    logic        bs_rd_en;
    logic [15:0] bs_rd_addr;
    logic [31:0] bs_rd_data = 32'd0;
    logic [1:0]  open_file;
    logic        bad_path;
    logic        bad_access;

    fs_dev_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fs_access   (fs_access),
        .fs_rden     (fs_rden),
        .fs_wren     (fs_wren),
        .fs_filename (fs_filename),
        .fs_address  (fs_address),
        .fs_data     (fs_data),
        .fs_q        (fs_q),
        .bs_wr_en    (bs_wr_en),
        .bs_wr_addr  (bs_wr_addr),
        .bs_wr_data  (bs_wr_data),
        .bs_rd_en    (bs_rd_en),
        .bs_rd_addr  (bs_rd_addr),
        .bs_rd_data  (bs_rd_data),
        .open_file   (open_file),
        .bad_path    (bad_path),
        .bad_access  (bad_access)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bs_init(input int a);
        if (a == 5) return 32'hDEADBEEF;
        return (32'(a) * 32'h01000193) ^ 32'h5BD1E995;
    endfunction

    // Backing store: synchronous, read returns the pre-write contents.
    logic [31:0] store [0:65535];
    bit          written [0:65535];
    always @(posedge clk) begin
        if (bs_rd_en)
            bs_rd_data <= written[bs_rd_addr] ? store[bs_rd_addr] : bs_init(int'(bs_rd_addr));
        if (bs_wr_en) begin
            store[bs_wr_addr]   <= bs_wr_data;
            written[bs_wr_addr] <= 1'b1;
        end
    end

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_exp_t;

    typedef struct {
        int          due;
        logic        wr_en;
        logic [15:0] wr_addr;
        logic [31:0] wr_data;
        logic        rd_en;
        logic [15:0] rd_addr;
    } st_exp_t;

    rd_exp_t rd_q[$];
    st_exp_t st_q[$];

    // Reference model state (driver side).
    logic [31:0] ref_mem  [int];
    logic [31:0] ref_meta [int];
    logic [31:0] m_path[$];
    logic [31:0] m_prev = 32'd0;
    logic [31:0] cur_name = 32'd0;
    logic [1:0]  exp_open = 2'd0;
    logic        exp_bad_path = 1'b0;
    logic        exp_bad_access = 1'b0;
    bit          checking = 1'b0;
    bit          done = 1'b0;
    int          cyc = 0;

    // Monitor-owned counters.
    int          checks = 0;
    int          errors = 0;
    logic [31:0] hold_val = 32'd0;
    rd_exp_t     r_cur;
    st_exp_t     s_cur;

    function automatic logic [31:0] legal_word(input int i);
        case (i)
            0: return P1;
            1: return P2;
            default: return P3;
        endcase
    endfunction

    function automatic bit path_is_prefix();
        if (m_path.size() > 3) return 1'b0;
        for (int i = 0; i < m_path.size(); i++)
            if (m_path[i] != legal_word(i)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_path(input logic [31:0] nm);
        if (nm != m_prev) begin
            m_prev   = nm;
            exp_open = 2'd0;
            if (nm == P1) begin
                m_path.delete();
                m_path.push_back(nm);
            end else if (nm == 32'd0) begin
                if (m_path.size() == 2) exp_open = 2'd1;
                else if (m_path.size() == 3) exp_open = 2'd2;
                else if (m_path.size() != 0) exp_bad_path = 1'b1;
                m_path.delete();
            end else begin
                m_path.push_back(nm);
                if (!path_is_prefix()) begin
                    exp_bad_path = 1'b1;
                    m_path.delete();
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [31:0] nm,
                        input logic [31:0] a, input logic [31:0] d);
        int          n;
        logic        legal;
        logic [15:0] bsa;
        logic [31:0] rv;
        @(negedge clk);
        n = cyc + 1;
        rst_n = 1'b1;
        fs_rden = r;
        fs_wren = w;
        fs_filename = nm;
        fs_address = a;
        fs_data = d;
        fs_access = 1'($urandom_range(0, 1));
        cur_name = nm;
        model_path(nm);
        legal = (exp_open == 2'd1 && a < 32'h8000) || (exp_open == 2'd2 && a < 32'd1024);
        bsa = (exp_open == 2'd2) ? 16'(32'd32768 + a) : a[15:0];
        if ((r || w) && !legal) exp_bad_access = 1'b1;
        if (w && legal) begin
            if (exp_open == 2'd1) ref_mem[int'(a)] = d;
            else ref_meta[int'(a)] = d;
        end
        rv = 32'd0;
        if (r && legal) begin
            if (exp_open == 2'd1)
                rv = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : bs_init(int'(a));
            else
                rv = ref_meta.exists(int'(a)) ? ref_meta[int'(a)] : bs_init(32768 + int'(a));
        end
        if (r) rd_q.push_back('{n + 2, rv});
        st_q.push_back('{n, w && legal, bsa, d, r && legal, bsa});
    endtask

    task automatic rst_step();
        int n;
        @(negedge clk);
        n = cyc + 1;
        rst_n = 1'b0;
        fs_rden = 1'b1;
        fs_wren = 1'b1;
        fs_address = 32'($urandom_range(0, 7));
        fs_data = $urandom;
        m_path.delete();
        m_prev = 32'd0;
        exp_open = 2'd0;
        exp_bad_path = 1'b0;
        exp_bad_access = 1'b0;
        rd_q.delete();
        rd_q.push_back('{n, 32'd0});
        st_q.push_back('{n, 1'b0, 16'd0, 32'd0, 1'b0, 16'd0});
        checking = 1'b1;
    endtask

    task automatic rand_step(input logic [31:0] nm);
        int          pick;
        logic [31:0] a;
        pick = $urandom_range(0, 9);
        if (pick < 7) a = 32'($urandom_range(0, 7));
        else if (pick == 7) a = 32'h8000 + 32'($urandom_range(0, 3));
        else if (pick == 8) a = 32'($urandom_range(1020, 1030));
        else a = $urandom;
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), nm, a, $urandom);
    endtask

    task automatic open_seq(input bit meta, input bit random_req);
        logic [31:0] seq [4];
        int          len;
        seq[0] = P1; seq[1] = P2;
        if (meta) begin seq[2] = P3; seq[3] = 32'd0; len = 4; end
        else begin seq[2] = 32'd0; len = 3; end
        for (int i = 0; i < len; i++) begin
            if (random_req) rand_step(seq[i]);
            else step(1'b0, 1'b0, seq[i], 32'd0, 32'd0);
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (checking) begin
            check("open_file", 32'(open_file), 32'(exp_open));
            check("bad_path", 32'(bad_path), 32'(exp_bad_path));
            check("bad_access", 32'(bad_access), 32'(exp_bad_access));
            if (st_q.size() > 0 && st_q[0].due == cyc) begin
                s_cur = st_q.pop_front();
                check("bs_wr_en", 32'(bs_wr_en), 32'(s_cur.wr_en));
                if (s_cur.wr_en) begin
                    check("bs_wr_addr", 32'(bs_wr_addr), 32'(s_cur.wr_addr));
                    check("bs_wr_data", bs_wr_data, s_cur.wr_data);
                end
                check("bs_rd_en", 32'(bs_rd_en), 32'(s_cur.rd_en));
                if (s_cur.rd_en) check("bs_rd_addr", 32'(bs_rd_addr), 32'(s_cur.rd_addr));
            end
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                r_cur = rd_q.pop_front();
                check("fs_q", fs_q, r_cur.data);
                hold_val = r_cur.data;
                $display("read cycle %0d fs_q %h expected %h", cyc, fs_q, r_cur.data);
            end else begin
                check("fs_q_hold", fs_q, hold_val);
            end
            if (done) begin
                check("drain", 32'(rd_q.size()), 32'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_step();
        rst_step();
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        // Open /dev/mem, read the preloaded word at 5.
        open_seq(1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 32'd5, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        // Open /dev/memmeta with a write on the final 0 word, then read back.
        step(1'b0, 1'b0, P1, 32'd0, 32'd0);
        step(1'b0, 1'b0, P2, 32'd0, 32'd0);
        step(1'b0, 1'b0, P3, 32'd0, 32'd0);
        step(1'b0, 1'b1, 32'd0, 32'd3, 32'hA);
        step(1'b1, 1'b0, 32'd0, 32'd3, 32'd0);
        // Write-then-read and same-edge write/read on /dev/mem.
        open_seq(1'b0, 1'b0);
        step(1'b0, 1'b1, 32'd0, 32'd7, 32'h1234);
        step(1'b1, 1'b0, 32'd0, 32'd7, 32'd0);
        step(1'b1, 1'b1, 32'd0, 32'd9, 32'h5678);
        step(1'b1, 1'b0, 32'd0, 32'd9, 32'd0);
        // Illegal path then access with nothing open.
        step(1'b0, 1'b0, P1, 32'd0, 32'd0);
        step(1'b0, 1'b0, BAD, 32'd0, 32'd0);
        step(1'b1, 1'b0, BAD, 32'd2, 32'd0);
        step(1'b0, 1'b0, BAD, 32'd0, 32'd0);
        step(1'b0, 1'b0, BAD, 32'd0, 32'd0);
        // Out-of-range address on /dev/mem.
        rst_step();
        open_seq(1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 32'h8000, 32'd0);
        step(1'b0, 1'b1, 32'd0, 32'h8000, 32'h55);
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        // Full read pipeline interrupted by reset, then reopen.
        rst_step();
        open_seq(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 32'(i), 32'd0);
        rst_step();
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        open_seq(1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 32'd5, 32'd0);
        // Randomized traffic with occasional path walks, junk words and resets.
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 2) rst_step();
            else if (sel < 6) open_seq(sel[0], 1'b1);
            else if (sel < 9) begin
                logic [31:0] words [5];
                words[0] = 32'd0; words[1] = P1; words[2] = P2; words[3] = P3; words[4] = BAD;
                rand_step(words[$urandom_range(0, 4)]);
            end else rand_step(cur_name);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, cur_name, 32'd0, 32'd0);
        @(negedge clk);
        done = 1'b1;
    end

endmodule
